// File: rtl/scan_pkg.sv
// Shared encodings for the scan sequencer: operating modes, FSM states and
// the code-range constants used by the sequencer datapath.
package scan_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_SINGLE   = 2'b10,
    MODE_PINGPONG = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [2:0] CODE_MIN = 3'd0;
  localparam logic [2:0] CODE_MAX = 3'd7;

  // Only the down-counting mode starts at the top of the range.
  function automatic logic [2:0] start_code(mode_e m);
    return (m == MODE_DOWN) ? CODE_MAX : CODE_MIN;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell prescaler: counts 0..div while enabled and flags the terminal count,
// so each select code is held for div+1 clock cycles.
module scan_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  assign tick = en && !clr && (count_q == div);

  // Wrapping on the terminal count (rather than overflowing) keeps div at
  // its maximum value safe: the counter never needs a wider range.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (tick) begin
        count_d = '0;
      end else begin
        count_d = count_q + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: walks a 3-bit select code through one of four patterns,
// holding each code for div+1 cycles. All outputs come straight from flops.
module scan_sequencer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [2:0]       A,
  output logic             valid,
  output logic             busy,
  output logic             sweep_done
);

  import scan_pkg::*;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             dir_up_q, dir_up_d;
  logic [2:0]       a_q, a_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  // The prescaler is held cleared in IDLE so every run starts a fresh dwell.
  scan_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ST_IDLE),
    .en    (state_q == ST_RUN),
    .div   (div_q),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    div_d    = div_q;
    dir_up_d = dir_up_q;
    a_d      = a_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d  = ST_RUN;
          mode_d   = mode_e'(mode);
          div_d    = div;
          a_d      = start_code(mode_e'(mode));
          dir_up_d = 1'b1;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (tick) begin
          case (mode_q)
            MODE_UP: begin
              a_d    = a_q + 3'd1;
              done_d = (a_q == CODE_MAX);
            end
            MODE_DOWN: begin
              a_d    = a_q - 3'd1;
              done_d = (a_q == CODE_MIN);
            end
            MODE_SINGLE: begin
              if (a_q == CODE_MAX) begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                a_d = a_q + 3'd1;
              end
            end
            MODE_PINGPONG: begin
              // Turn around one step early so each end code is shown once.
              if (dir_up_q) begin
                a_d = a_q + 3'd1;
                if (a_q == 3'd6) begin
                  dir_up_d = 1'b0;
                end
              end else begin
                a_d = a_q - 3'd1;
                if (a_q == 3'd1) begin
                  dir_up_d = 1'b1;
                  done_d   = 1'b1;
                end
              end
            end
            default: begin
              a_d = a_q;
            end
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_UP;
      div_q    <= '0;
      dir_up_q <= 1'b1;
      a_q      <= CODE_MIN;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      div_q    <= div_d;
      dir_up_q <= dir_up_d;
      a_q      <= a_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign A          = a_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: directed scenarios with literal
// expectations, then random stimulus against a cycle-index reference model.
module tb_scan_sequencer;

  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [DIV_W-1:0] div = '0;
  logic [2:0]       A;
  logic             valid;
  logic             busy;
  logic             sweep_done;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Reference model state: the expected outputs are derived from the number
  // of cycles k elapsed since the run began, not from any step-by-step code.
  bit         m_run = 1'b0;
  int         m_k = 0;
  int         m_mode = 0;
  int         m_div = 0;
  logic [2:0] m_a = 3'd0;
  logic       m_valid = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;

  always #5 clk = ~clk;

  scan_sequencer #(
    .DIV_W (DIV_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .div        (div),
    .A          (A),
    .valid      (valid),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  function automatic int exp_code(int m, int d, int k);
    int s;
    int p;
    s = k / (d + 1);
    case (m)
      0:       return s % 8;
      1:       return 7 - (s % 8);
      2:       return (s < 8) ? s : 7;
      default: begin
        p = s % 14;
        return (p <= 7) ? p : 14 - p;
      end
    endcase
  endfunction

  function automatic bit exp_done(int m, int d, int k);
    int s;
    if (k == 0 || (k % (d + 1)) != 0) return 1'b0;
    s = k / (d + 1);
    case (m)
      0, 1:    return (s % 8) == 0;
      2:       return s == 8;
      default: return (s % 14) == 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run   <= 1'b0;
      m_k     <= 0;
      m_a     <= 3'd0;
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
    end else if (!m_run) begin
      m_done <= 1'b0;
      if (start && !stop) begin
        m_run   <= 1'b1;
        m_k     <= 0;
        m_mode  <= int'(mode);
        m_div   <= int'(div);
        m_a     <= (mode == 2'b01) ? 3'd7 : 3'd0;
        m_valid <= 1'b1;
        m_busy  <= 1'b1;
      end
    end else if (stop) begin
      m_run   <= 1'b0;
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
    end else begin
      m_k    <= m_k + 1;
      m_a    <= 3'(exp_code(m_mode, m_div, m_k + 1));
      m_done <= exp_done(m_mode, m_div, m_k + 1);
      if (m_mode == 2 && (m_k + 1) == 8 * (m_div + 1)) begin
        m_run   <= 1'b0;
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle's inputs at a falling edge and advances to the next one.
  task automatic applyStimulus(input logic s, input logic p, input logic [1:0] m,
                               input logic [DIV_W-1:0] d);
    start = s;
    stop  = p;
    mode  = m;
    div   = d;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cmp_A", {29'd0, A}, {29'd0, m_a});
      checkOutput("cmp_valid", {31'd0, valid}, {31'd0, m_valid});
      checkOutput("cmp_busy", {31'd0, busy}, {31'd0, m_busy});
      checkOutput("cmp_sweep_done", {31'd0, sweep_done}, {31'd0, m_done});
    end
  end

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 4'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("rst_A", {29'd0, A}, 32'd0);
    checkOutput("rst_valid", {31'd0, valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_sweep_done", {31'd0, sweep_done}, 32'd0);
    cmp_en = 1'b1;
    rst_n  = 1'b1;

    $display("[TB] continuous up, div=0");
    applyStimulus(1'b1, 1'b0, 2'b00, 4'd0);
    checkOutput("up_entry_A", {29'd0, A}, 32'd0);
    checkOutput("up_entry_busy", {31'd0, busy}, 32'd1);
    repeat (7) applyStimulus(1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("up_top_A", {29'd0, A}, 32'd7);
    applyStimulus(1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("up_wrap_A", {29'd0, A}, 32'd0);
    checkOutput("up_wrap_done", {31'd0, sweep_done}, 32'd1);
    checkOutput("up_model_done", {31'd0, m_done}, 32'd1);
    applyStimulus(1'b0, 1'b1, 2'b00, 4'd0);

    $display("[TB] single sweep, div=2");
    applyStimulus(1'b1, 1'b0, 2'b10, 4'd2);
    repeat (23) applyStimulus(1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("single_last_A", {29'd0, A}, 32'd7);
    checkOutput("single_last_busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("single_end_busy", {31'd0, busy}, 32'd0);
    checkOutput("single_end_valid", {31'd0, valid}, 32'd0);
    checkOutput("single_end_A", {29'd0, A}, 32'd7);
    checkOutput("single_end_done", {31'd0, sweep_done}, 32'd1);
    checkOutput("single_model_done", {31'd0, m_done}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("single_after_done", {31'd0, sweep_done}, 32'd0);

    $display("[TB] ping-pong, div=0");
    applyStimulus(1'b1, 1'b0, 2'b11, 4'd0);
    repeat (7) applyStimulus(1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("pp_top_A", {29'd0, A}, 32'd7);
    checkOutput("pp_top_done", {31'd0, sweep_done}, 32'd0);
    repeat (7) applyStimulus(1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("pp_return_A", {29'd0, A}, 32'd0);
    checkOutput("pp_return_done", {31'd0, sweep_done}, 32'd1);
    checkOutput("pp_model_A", {29'd0, m_a}, 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b00, 4'd0);

    $display("[TB] continuous down, div=1, stop");
    applyStimulus(1'b1, 1'b0, 2'b01, 4'd1);
    checkOutput("down_entry_A", {29'd0, A}, 32'd7);
    repeat (4) applyStimulus(1'b0, 1'b0, 2'b01, 4'd1);
    checkOutput("down_A5", {29'd0, A}, 32'd5);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'd1);
    checkOutput("stop_A", {29'd0, A}, 32'd5);
    checkOutput("stop_busy", {31'd0, busy}, 32'd0);
    checkOutput("stop_valid", {31'd0, valid}, 32'd0);
    checkOutput("stop_done", {31'd0, sweep_done}, 32'd0);
    applyStimulus(1'b1, 1'b1, 2'b00, 4'd0);
    checkOutput("start_stop_busy", {31'd0, busy}, 32'd0);

    $display("[TB] mid-run changes and reset");
    applyStimulus(1'b1, 1'b0, 2'b00, 4'd0);
    repeat (4) applyStimulus(1'b1, 1'b0, 2'b11, 4'd5);
    checkOutput("midrun_A", {29'd0, A}, 32'd4);
    checkOutput("midrun_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b00, 4'd0);
    checkOutput("midrst_A", {29'd0, A}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_valid", {31'd0, valid}, 32'd0);
    checkOutput("midrst_done", {31'd0, sweep_done}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] maximum dwell");
    applyStimulus(1'b1, 1'b0, 2'b00, 4'd15);
    repeat (15) applyStimulus(1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("maxdiv_hold_A", {29'd0, A}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("maxdiv_step_A", {29'd0, A}, 32'd1);
    repeat (112) applyStimulus(1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("maxdiv_wrap_A", {29'd0, A}, 32'd0);
    checkOutput("maxdiv_wrap_done", {31'd0, sweep_done}, 32'd1);
    applyStimulus(1'b0, 1'b1, 2'b00, 4'd0);

    $display("[TB] random stimulus");
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      applyStimulus(($urandom % 4) == 0, ($urandom % 24) == 0, 2'($urandom % 4),
                    (($urandom % 8) == 0) ? 4'd15 : 4'($urandom_range(0, 3)));
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 2'b00, 4'd0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
